// File: rtl/player_pkg.sv
// Shared player types: playback state encoding, BCD digit type and the
// small constants used by the timer and its display converters.
package player_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUNNING  = 2'd1,
      PAUSED   = 2'd2,
      FINISHED = 2'd3
   } play_state_t;

   typedef logic [3:0] bcd_t;

   localparam int SECS_PER_MIN = 60;

   function automatic int pow10(input int n);
      int p;
      p = 1;
      for (int i = 0; i < n; i++) begin
         p = p * 10;
      end
      return p;
   endfunction

endpackage

// File: rtl/mmss_bcd.sv
// Registered binary-seconds to BCD mm:ss converter. Minutes beyond what
// MIN_DIGITS can show saturate the whole display to all-9 minutes and 59 s.
module mmss_bcd
   import player_pkg::*;
#(
   parameter int SEC_W      = 12,
   parameter int MIN_DIGITS = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [SEC_W-1:0]        secs,
   output bcd_t                    sec0,
   output bcd_t                    sec1,
   output logic [4*MIN_DIGITS-1:0] min_bcd
);

   localparam logic [31:0] MAX_MIN = 32'(pow10(MIN_DIGITS) - 1);

   logic [SEC_W-1:0]        minutes;
   logic [SEC_W-1:0]        rem;
   logic [SEC_W-1:0]        q;
   bcd_t                    sec0_n;
   bcd_t                    sec1_n;
   logic [4*MIN_DIGITS-1:0] min_n;

   always_comb begin
      minutes = secs / SEC_W'(SECS_PER_MIN);
      rem     = secs % SEC_W'(SECS_PER_MIN);
      q       = minutes;
      min_n   = '0;
      for (int i = 0; i < MIN_DIGITS; i++) begin
         min_n[4*i +: 4] = 4'(q % SEC_W'(10));
         q               = q / SEC_W'(10);
      end
      sec0_n = 4'(rem % SEC_W'(10));
      sec1_n = 4'(rem / SEC_W'(10));
      if (32'(minutes) > MAX_MIN) begin
         min_n  = {MIN_DIGITS{4'd9}};
         sec1_n = 4'd5;
         sec0_n = 4'd9;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sec0    <= '0;
         sec1    <= '0;
         min_bcd <= '0;
      end else begin
         sec0    <= sec0_n;
         sec1    <= sec1_n;
         min_bcd <= min_n;
      end
   end

endmodule

// File: rtl/track_timer.sv
// Elapsed-playback timer: 1 Hz prescaler, pause/resume, clamped signed seek
// and end-of-track detection, feeding registered BCD mm:ss digits.
//
// state    | meaning
// IDLE     | cleared, waiting for run
// RUNNING  | prescaler counting, elapsed advancing once per second
// PAUSED   | prescaler and elapsed held (fractional second kept)
// FINISHED | elapsed reached track_len; leaves on seek below end or clear
module track_timer
   import player_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int SEC_W      = 12,
   parameter int MIN_DIGITS = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    run,
   input  logic                    seek_valid,
   input  logic [SEC_W:0]          seek_delta,
   input  logic [SEC_W-1:0]        track_len,
   output logic [SEC_W-1:0]        elapsed,
   output logic [3:0]              sec0,
   output logic [3:0]              sec1,
   output logic [4*MIN_DIGITS-1:0] min_bcd,
   output logic                    tick,
   output logic                    done,
   output logic                    running
);

   localparam int            PW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);

   play_state_t              state;
   play_state_t              state_n;
   logic [PW-1:0]            presc;
   logic [PW-1:0]            presc_n;
   logic [SEC_W-1:0]         elapsed_n;
   logic                     tick_n;
   logic                     done_n;
   logic signed [SEC_W+1:0]  seek_sum;
   logic [SEC_W-1:0]         seek_target;

   // Two extra bits keep elapsed + delta free of overflow before clamping.
   assign seek_sum = $signed({2'b00, elapsed}) + $signed({seek_delta[SEC_W], seek_delta});

   always_comb begin
      seek_target = seek_sum[SEC_W-1:0];
      if (seek_sum[SEC_W+1]) begin
         seek_target = '0;
      end else if (seek_sum > $signed({2'b00, track_len})) begin
         seek_target = track_len;
      end
   end

   always_comb begin
      state_n   = state;
      presc_n   = presc;
      elapsed_n = elapsed;
      tick_n    = 1'b0;
      if (clear) begin
         state_n   = IDLE;
         presc_n   = '0;
         elapsed_n = '0;
      end else if (seek_valid) begin
         // A prescaler wrap in this cycle is dropped along with its tick.
         presc_n   = '0;
         elapsed_n = seek_target;
         case (state)
            RUNNING: begin
               if (seek_target >= track_len) begin
                  state_n = FINISHED;
               end else if (!run) begin
                  state_n = PAUSED;
               end
            end
            PAUSED: begin
               if (run) begin
                  state_n = RUNNING;
               end
            end
            FINISHED: begin
               if (seek_target < track_len) begin
                  state_n = PAUSED;
               end
            end
            default: ;
         endcase
      end else begin
         if (elapsed > track_len) begin
            elapsed_n = track_len;
         end
         case (state)
            IDLE, PAUSED: begin
               if (run) begin
                  state_n = RUNNING;
               end
            end
            RUNNING: begin
               if (elapsed >= track_len) begin
                  state_n = FINISHED;
               end else if (!run) begin
                  state_n = PAUSED;
               end else if (presc == PRE_TC) begin
                  presc_n   = '0;
                  elapsed_n = elapsed + SEC_W'(1);
                  tick_n    = 1'b1;
                  if (elapsed + SEC_W'(1) == track_len) begin
                     state_n = FINISHED;
                  end
               end else begin
                  presc_n = presc + PW'(1);
               end
            end
            default: ;
         endcase
      end
      done_n = (state_n == FINISHED) && (state != FINISHED);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         presc   <= '0;
         elapsed <= '0;
         tick    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         presc   <= presc_n;
         elapsed <= elapsed_n;
         tick    <= tick_n;
         done    <= done_n;
      end
   end

   assign running = (state == RUNNING);

   mmss_bcd #(
      .SEC_W      (SEC_W),
      .MIN_DIGITS (MIN_DIGITS)
   ) u_mmss (
      .clk     (clk),
      .reset   (reset),
      .secs    (elapsed),
      .sec0    (sec0),
      .sec1    (sec1),
      .min_bcd (min_bcd)
   );

endmodule

// File: tb/tb_track_timer.sv
// Self-checking bench for track_timer at CLK_HZ=4: directed scenarios plus a
// randomized run against a behavioural model of the playback rules.
module tb_track_timer;

   localparam int CLK_HZ = 4;
   localparam int SEC_W  = 12;

   localparam int S_IDLE  = 0;
   localparam int S_RUN   = 1;
   localparam int S_PAUSE = 2;
   localparam int S_FIN   = 3;

   logic             clk;
   logic             reset;
   logic             clear;
   logic             run;
   logic             seek_valid;
   logic [SEC_W:0]   seek_delta;
   logic [SEC_W-1:0] track_len;

   logic [SEC_W-1:0] elapsed,  elapsed1;
   logic [3:0]       sec0,     sec0_1;
   logic [3:0]       sec1,     sec1_1;
   logic [7:0]       min_bcd;
   logic [3:0]       min_bcd1;
   logic             tick,     tick1;
   logic             done,     done1;
   logic             running,  running1;

   int n_cmp  = 0;
   int n_fail = 0;

   // behavioural model
   int m_st, m_el, m_frac, m_disp;
   bit m_tick, m_done;

   track_timer #(.CLK_HZ(CLK_HZ), .SEC_W(SEC_W), .MIN_DIGITS(2)) dut (
      .clk(clk), .reset(reset), .clear(clear), .run(run),
      .seek_valid(seek_valid), .seek_delta(seek_delta), .track_len(track_len),
      .elapsed(elapsed), .sec0(sec0), .sec1(sec1), .min_bcd(min_bcd),
      .tick(tick), .done(done), .running(running)
   );

   track_timer #(.CLK_HZ(CLK_HZ), .SEC_W(SEC_W), .MIN_DIGITS(1)) dut1 (
      .clk(clk), .reset(reset), .clear(clear), .run(run),
      .seek_valid(seek_valid), .seek_delta(seek_delta), .track_len(track_len),
      .elapsed(elapsed1), .sec0(sec0_1), .sec1(sec1_1), .min_bcd(min_bcd1),
      .tick(tick1), .done(done1), .running(running1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit expired, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   // mm:ss display expected for a seconds value on a display of 'digits' minute digits
   function automatic logic [19:0] exp_disp(input int secs, input int digits);
      int mins, s, lim, p;
      logic [11:0] mb;
      mins = secs / 60;
      s    = secs % 60;
      lim  = 1;
      for (int i = 0; i < digits; i++) lim = lim * 10;
      mb = '0;
      if (mins > lim - 1) begin
         for (int i = 0; i < digits; i++) mb[4*i +: 4] = 4'd9;
         s = 59;
      end else begin
         p = mins;
         for (int i = 0; i < digits; i++) begin
            mb[4*i +: 4] = 4'(p % 10);
            p = p / 10;
         end
      end
      return {mb, 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic model_step();
      int prev, tl, tgt;
      prev   = m_st;
      tl     = int'(track_len);
      m_tick = 1'b0;
      if (reset) begin
         m_st = S_IDLE; m_el = 0; m_frac = 0; m_disp = 0; m_done = 1'b0;
         return;
      end
      m_disp = m_el;
      if (clear) begin
         m_st = S_IDLE; m_el = 0; m_frac = 0;
      end else if (seek_valid) begin
         tgt = m_el + int'($signed(seek_delta));
         if (tgt < 0)  tgt = 0;
         if (tgt > tl) tgt = tl;
         m_el   = tgt;
         m_frac = 0;
         if (m_st == S_RUN)        m_st = (tgt >= tl) ? S_FIN : (run ? S_RUN : S_PAUSE);
         else if (m_st == S_PAUSE) m_st = run ? S_RUN : S_PAUSE;
         else if (m_st == S_FIN)   m_st = (tgt < tl) ? S_PAUSE : S_FIN;
      end else if (m_st == S_RUN && m_el >= tl) begin
         m_el = tl;
         m_st = S_FIN;
      end else begin
         if (m_el > tl) m_el = tl;
         if (m_st == S_IDLE || m_st == S_PAUSE) begin
            if (run) m_st = S_RUN;
         end else if (m_st == S_RUN) begin
            if (!run) m_st = S_PAUSE;
            else begin
               m_frac++;
               if (m_frac == CLK_HZ) begin
                  m_frac = 0;
                  m_el++;
                  m_tick = 1'b1;
                  if (m_el >= tl) m_st = S_FIN;
               end
            end
         end
      end
      m_done = (m_st == S_FIN) && (prev != S_FIN);
   endtask

   task automatic tick_clk();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_clear();
      run = 1'b0; clear = 1'b1;
      tick_clk();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick_clk();
      tick_clk();
      n_cmp++;
      if ({elapsed, tick, done, running} !== '0) begin
         n_fail++; $display("FAIL reset_hold: actual el=%0d t=%0b d=%0b r=%0b required all 0", elapsed, tick, done, running);
      end
      reset = 1'b0;
      tick_clk();
      n_cmp++;
      if ({elapsed, sec0, sec1, min_bcd, tick, done, running} !== '0) begin
         n_fail++; $display("FAIL reset_release: actual el=%0d %h:%h%h t=%0b d=%0b r=%0b required all 0",
                             elapsed, min_bcd, sec1, sec0, tick, done, running);
      end
   endtask

   task automatic test_count();
      int nt;
      logic exp_t;
      track_len = 12'd200;
      do_clear();
      run = 1'b1;
      tick_clk();
      n_cmp++;
      if (running !== 1'b1) begin
         n_fail++; $display("FAIL count_start: running actual %0b required 1", running);
      end
      nt = 0;
      for (int i = 0; i < 300; i++) begin
         tick_clk();
         exp_t = (i % 4 == 3);
         if (tick) nt++;
         n_cmp++;
         if (tick !== exp_t) begin
            n_fail++; $display("FAIL count_tick[%0d]: actual %0b required %0b", i, tick, exp_t);
         end
      end
      n_cmp++;
      if (elapsed !== 12'd75 || nt != 75) begin
         n_fail++; $display("FAIL count_elapsed: actual %0d (ticks %0d) required 75", elapsed, nt);
      end
      tick_clk();
      n_cmp++;
      if (min_bcd !== 8'h01 || sec1 !== 4'd1 || sec0 !== 4'd5) begin
         n_fail++; $display("FAIL count_digits: actual %h:%h%h required 01:15", min_bcd, sec1, sec0);
      end
   endtask

   task automatic test_pause_resume();
      track_len = 12'd200;
      do_clear();
      run = 1'b1;
      tick_clk();
      tick_clk();
      tick_clk();
      run = 1'b0;
      tick_clk();
      n_cmp++;
      if (running !== 1'b0) begin
         n_fail++; $display("FAIL pause_enter: running actual %0b required 0", running);
      end
      for (int i = 0; i < 10; i++) begin
         tick_clk();
         n_cmp++;
         if (tick !== 1'b0 || elapsed !== 12'd0) begin
            n_fail++; $display("FAIL pause_hold[%0d]: tick %0b el %0d required 0 0", i, tick, elapsed);
         end
      end
      run = 1'b1;
      tick_clk();
      n_cmp++;
      if (running !== 1'b1 || tick !== 1'b0) begin
         n_fail++; $display("FAIL resume: running %0b tick %0b required 1 0", running, tick);
      end
      tick_clk();
      n_cmp++;
      if (tick !== 1'b0) begin
         n_fail++; $display("FAIL resume_early: tick actual %0b required 0", tick);
      end
      tick_clk();
      n_cmp++;
      if (tick !== 1'b1 || elapsed !== 12'd1) begin
         n_fail++; $display("FAIL resume_tick: tick %0b el %0d required 1 1", tick, elapsed);
      end
   endtask

   task automatic test_seek();
      int nd;
      track_len = 12'd200;
      do_clear();
      seek_delta = 13'd10; seek_valid = 1'b1;
      tick_clk();
      seek_valid = 1'b0;
      n_cmp++;
      if (elapsed !== 12'd10 || running !== 1'b0) begin
         n_fail++; $display("FAIL seek_idle: el %0d running %0b required 10 0", elapsed, running);
      end
      run = 1'b1;
      tick_clk();
      seek_delta = 13'd500; seek_valid = 1'b1;
      tick_clk();
      seek_valid = 1'b0;
      n_cmp++;
      if (elapsed !== 12'd200 || done !== 1'b1 || running !== 1'b0) begin
         n_fail++; $display("FAIL seek_end: el %0d done %0b running %0b required 200 1 0", elapsed, done, running);
      end
      nd = 0;
      for (int i = 0; i < 6; i++) begin
         tick_clk();
         if (done) nd++;
      end
      n_cmp++;
      if (nd != 0 || elapsed !== 12'd200 || running !== 1'b0) begin
         n_fail++; $display("FAIL seek_finished_hold: extra done %0d el %0d running %0b required 0 200 0", nd, elapsed, running);
      end
      run = 1'b0;
      seek_delta = 13'(-50); seek_valid = 1'b1;
      tick_clk();
      seek_valid = 1'b0;
      n_cmp++;
      if (elapsed !== 12'd150 || running !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL seek_back: el %0d running %0b done %0b required 150 0 0", elapsed, running, done);
      end
      run = 1'b1;
      tick_clk();
      n_cmp++;
      if (running !== 1'b1) begin
         n_fail++; $display("FAIL seek_paused_resume: running actual %0b required 1", running);
      end
      // negative clamp
      do_clear();
      seek_delta = 13'd5; seek_valid = 1'b1;
      tick_clk();
      seek_delta = 13'(-20);
      tick_clk();
      seek_valid = 1'b0;
      n_cmp++;
      if (elapsed !== 12'd0) begin
         n_fail++; $display("FAIL seek_neg: el actual %0d required 0", elapsed);
      end
   endtask

   task automatic test_seek_on_wrap();
      track_len = 12'd200;
      do_clear();
      run = 1'b1;
      tick_clk();
      for (int i = 0; i < 3; i++) tick_clk();
      seek_delta = 13'd3; seek_valid = 1'b1;
      tick_clk();
      seek_valid = 1'b0;
      n_cmp++;
      if (tick !== 1'b0 || elapsed !== 12'd3) begin
         n_fail++; $display("FAIL wrap_seek: tick %0b el %0d required 0 3", tick, elapsed);
      end
      for (int i = 0; i < 3; i++) begin
         tick_clk();
         n_cmp++;
         if (tick !== 1'b0) begin
            n_fail++; $display("FAIL wrap_restart[%0d]: tick actual %0b required 0", i, tick);
         end
      end
      tick_clk();
      n_cmp++;
      if (tick !== 1'b1 || elapsed !== 12'd4) begin
         n_fail++; $display("FAIL wrap_next_tick: tick %0b el %0d required 1 4", tick, elapsed);
      end
   endtask

   task automatic test_limit_lower();
      track_len = 12'd200;
      do_clear();
      seek_delta = 13'd42; seek_valid = 1'b1;
      tick_clk();
      seek_valid = 1'b0;
      run = 1'b1;
      tick_clk();
      track_len = 12'd30;
      tick_clk();
      n_cmp++;
      if (elapsed !== 12'd30 || done !== 1'b1 || running !== 1'b0) begin
         n_fail++; $display("FAIL limit_clamp: el %0d done %0b running %0b required 30 1 0", elapsed, done, running);
      end
      tick_clk();
      n_cmp++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL limit_done_once: done actual %0b required 0", done);
      end
      do_clear();
      n_cmp++;
      if (elapsed !== 12'd0 || running !== 1'b0) begin
         n_fail++; $display("FAIL limit_clear: el %0d running %0b required 0 0", elapsed, running);
      end
      track_len = 12'd200;
      run = 1'b1;
      tick_clk();
      n_cmp++;
      if (running !== 1'b1) begin
         n_fail++; $display("FAIL limit_idle_restart: running actual %0b required 1", running);
      end
   endtask

   task automatic test_zero_len();
      track_len = 12'd0;
      do_clear();
      run = 1'b1;
      tick_clk();
      n_cmp++;
      if (running !== 1'b1 || done !== 1'b0) begin
         n_fail++; $display("FAIL zero_run: running %0b done %0b required 1 0", running, done);
      end
      tick_clk();
      n_cmp++;
      if (running !== 1'b0 || done !== 1'b1 || tick !== 1'b0 || elapsed !== 12'd0) begin
         n_fail++; $display("FAIL zero_finish: running %0b done %0b tick %0b el %0d required 0 1 0 0",
                             running, done, tick, elapsed);
      end
      tick_clk();
      n_cmp++;
      if (done !== 1'b0 || tick !== 1'b0) begin
         n_fail++; $display("FAIL zero_after: done %0b tick %0b required 0 0", done, tick);
      end
   endtask

   task automatic test_display_sat();
      track_len = 12'd4095;
      do_clear();
      seek_delta = 13'd700; seek_valid = 1'b1;
      tick_clk();
      seek_valid = 1'b0;
      n_cmp++;
      if (elapsed !== 12'd700 || elapsed1 !== 12'd700) begin
         n_fail++; $display("FAIL disp_elapsed: el %0d/%0d required 700", elapsed, elapsed1);
      end
      tick_clk();
      n_cmp++;
      if (min_bcd1 !== 4'h9 || sec1_1 !== 4'd5 || sec0_1 !== 4'd9) begin
         n_fail++; $display("FAIL disp_sat1: actual %h:%h%h required 9:59", min_bcd1, sec1_1, sec0_1);
      end
      n_cmp++;
      if (min_bcd !== 8'h11 || sec1 !== 4'd4 || sec0 !== 4'd0) begin
         n_fail++; $display("FAIL disp_two: actual %h:%h%h required 11:40", min_bcd, sec1, sec0);
      end
   endtask

   task automatic test_reset_mid();
      track_len = 12'd200;
      do_clear();
      run = 1'b1;
      tick_clk();
      for (int i = 0; i < 14; i++) tick_clk();
      n_cmp++;
      if (elapsed !== 12'd3) begin
         n_fail++; $display("FAIL rmid_pre: el actual %0d required 3", elapsed);
      end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({elapsed, sec0, sec1, min_bcd, tick, done, running} !== '0) begin
         n_fail++; $display("FAIL rmid_immediate: el %0d %h:%h%h t=%0b d=%0b r=%0b required all 0",
                             elapsed, min_bcd, sec1, sec0, tick, done, running);
      end
      tick_clk();
      tick_clk();
      n_cmp++;
      if ({elapsed, tick, done, running} !== '0) begin
         n_fail++; $display("FAIL rmid_hold: el %0d t=%0b d=%0b r=%0b required all 0", elapsed, tick, done, running);
      end
      run = 1'b0;
      reset = 1'b0;
      tick_clk();
   endtask

   task automatic test_random();
      logic [19:0] e2, e1;
      int d;
      for (int c = 0; c < 2500; c++) begin
         clear      = ($urandom_range(0, 199) == 0);
         run        = ($urandom_range(0, 9) != 0);
         seek_valid = ($urandom_range(0, 24) == 0);
         d          = int'($urandom_range(0, 600)) - 300;
         seek_delta = 13'(d);
         if ($urandom_range(0, 59) == 0) track_len = 12'($urandom_range(0, 400));
         tick_clk();
         e2 = exp_disp(m_disp, 2);
         e1 = exp_disp(m_disp, 1);
         n_cmp++;
         if (elapsed !== 12'(m_el) || elapsed1 !== 12'(m_el)) begin
            n_fail++; $display("FAIL rnd_elapsed[%0d]: actual %0d/%0d required %0d", c, elapsed, elapsed1, m_el);
         end
         n_cmp++;
         if (tick !== m_tick || tick1 !== m_tick) begin
            n_fail++; $display("FAIL rnd_tick[%0d]: actual %0b/%0b required %0b", c, tick, tick1, m_tick);
         end
         n_cmp++;
         if (done !== m_done || done1 !== m_done) begin
            n_fail++; $display("FAIL rnd_done[%0d]: actual %0b/%0b required %0b", c, done, done1, m_done);
         end
         n_cmp++;
         if (running !== (m_st == S_RUN) || running1 !== (m_st == S_RUN)) begin
            n_fail++; $display("FAIL rnd_running[%0d]: actual %0b/%0b required %0b", c, running, running1, m_st == S_RUN);
         end
         n_cmp++;
         if ({min_bcd, sec1, sec0} !== e2[15:0] || {min_bcd1, sec1_1, sec0_1} !== e1[11:0]) begin
            n_fail++; $display("FAIL rnd_digits[%0d]: actual %h:%h%h / %h:%h%h required %h / %h",
                                c, min_bcd, sec1, sec0, min_bcd1, sec1_1, sec0_1, e2[15:0], e1[11:0]);
         end
      end
      clear = 1'b0; run = 1'b0; seek_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; run = 1'b0; seek_valid = 1'b0;
      seek_delta = '0; track_len = 12'd200;
      m_st = S_IDLE; m_el = 0; m_frac = 0; m_disp = 0; m_tick = 1'b0; m_done = 1'b0;
      test_reset();
      test_count();
      test_pause_resume();
      test_seek();
      test_seek_on_wrap();
      test_limit_lower();
      test_zero_len();
      test_display_sat();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
